// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: programmable MDC divider, preamble length and post-frame gap.
// Define MDIO_CL45_EN to add the Clause 45 frame selection inputs (miim_cl45, miim_op45).
module mdio_master #(
  parameter int CLK_DIV   = 10,
  parameter int PRE_LEN   = 32,
  parameter int IDLE_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  miim_phyad,
  input  logic [4:0]  miim_regad,
  input  logic [15:0] miim_wrdata,
  input  logic        miim_wren,
  input  logic        miim_rden,
`ifdef MDIO_CL45_EN
  input  logic        miim_cl45,
  input  logic [1:0]  miim_op45,
`endif
  output logic [15:0] miim_rddata,
  output logic        miim_rddata_valid,
  output logic        miim_busy,
  output logic        phy_mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0] PRE_LAST = 8'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [7:0] GAP_LAST = 8'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_GAP} state_t;

  state_t           r_state, w_state_next;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic             r_mdc, w_mdc_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [31:0]      r_sh, w_sh_next;
  logic             r_rd, w_rd_next;
  logic [15:0]      r_rx, w_rx_next;
  logic             r_o, w_o_next;
  logic             r_oe, w_oe_next;
  logic             r_busy, w_busy_next;
  logic [15:0]      r_rddata, w_rddata_next;
  logic             r_valid, w_valid_next;

  logic [1:0]  w_st;
  logic [1:0]  w_op;
  logic        w_is_rd;
  logic [31:0] w_frame;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;

`ifdef MDIO_CL45_EN
  always_comb begin
    if (miim_cl45) begin
      w_st    = 2'b00;
      w_op    = miim_op45;
      w_is_rd = miim_op45[1];
    end else begin
      w_st    = 2'b01;
      w_op    = miim_wren ? 2'b01 : 2'b10;
      w_is_rd = ~miim_wren;
    end
  end
`else
  assign w_st    = 2'b01;
  assign w_op    = miim_wren ? 2'b01 : 2'b10;
  assign w_is_rd = ~miim_wren;
`endif

  // Everything after the preamble is one 32-bit shift word; the TA pair is only driven on writes.
  assign w_frame = {w_st, w_op, miim_phyad, miim_regad, 2'b10, miim_wrdata};

  assign w_tick = r_busy && (r_div == DIV_LAST);
  assign w_rise = w_tick & ~r_mdc;
  assign w_fall = w_tick & r_mdc;

  always_comb begin
    w_state_next  = r_state;
    w_div_next    = r_div;
    w_mdc_next    = r_mdc;
    w_cnt_next    = r_cnt;
    w_sh_next     = r_sh;
    w_rd_next     = r_rd;
    w_rx_next     = r_rx;
    w_o_next      = r_o;
    w_oe_next     = r_oe;
    w_busy_next   = r_busy;
    w_rddata_next = r_rddata;
    w_valid_next  = 1'b0;

    if (r_busy) begin
      w_div_next = w_tick ? '0 : r_div + 1'b1;
      if (w_tick) w_mdc_next = ~r_mdc;
    end

    case (r_state)
      S_IDLE: begin
        if (miim_wren | miim_rden) begin
          w_busy_next = 1'b1;
          w_sh_next   = w_frame;
          w_rd_next   = w_is_rd;
          w_cnt_next  = '0;
          w_div_next  = '0;
          w_mdc_next  = 1'b0;
          w_oe_next   = 1'b1;
          if (PRE_LEN > 0) begin
            w_state_next = S_PRE;
            w_o_next     = 1'b1;
          end else begin
            w_state_next = S_HDR;
            w_o_next     = w_frame[31];
          end
        end
      end
      S_PRE: begin
        if (w_fall) begin
          if (r_cnt == PRE_LAST) begin
            w_state_next = S_HDR;
            w_cnt_next   = '0;
            w_o_next     = r_sh[31];
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      S_HDR: begin
        if (w_fall) begin
          w_sh_next = r_sh << 1;
          if (r_cnt == 8'd13) begin
            w_state_next = S_TA;
            w_cnt_next   = '0;
            if (r_rd) begin
              w_oe_next = 1'b0;
              w_o_next  = 1'b1;
            end else begin
              w_o_next = r_sh[30];
            end
          end else begin
            w_cnt_next = r_cnt + 8'd1;
            w_o_next   = r_sh[30];
          end
        end
      end
      S_TA: begin
        if (w_fall) begin
          w_sh_next = r_sh << 1;
          if (!r_rd) w_o_next = r_sh[30];
          if (r_cnt == 8'd1) begin
            w_state_next = S_DATA;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (w_rise && r_rd) begin
          w_rx_next = {r_rx[14:0], mdio_i};
          if (r_cnt == 8'd15) begin
            w_rddata_next = {r_rx[14:0], mdio_i};
            w_valid_next  = 1'b1;
          end
        end
        if (w_fall) begin
          w_sh_next = r_sh << 1;
          if (r_cnt == 8'd15) begin
            w_cnt_next   = '0;
            w_oe_next    = 1'b0;
            w_o_next     = 1'b1;
            w_state_next = (IDLE_BITS > 0) ? S_GAP : S_IDLE;
            if (IDLE_BITS == 0) w_busy_next = 1'b0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
            if (!r_rd) w_o_next = r_sh[30];
          end
        end
      end
      S_GAP: begin
        if (w_fall) begin
          if (r_cnt == GAP_LAST) begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_mdc    <= 1'b0;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_rd     <= 1'b0;
      r_rx     <= '0;
      r_o      <= 1'b1;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_rddata <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_div_next;
      r_mdc    <= w_mdc_next;
      r_cnt    <= w_cnt_next;
      r_sh     <= w_sh_next;
      r_rd     <= w_rd_next;
      r_rx     <= w_rx_next;
      r_o      <= w_o_next;
      r_oe     <= w_oe_next;
      r_busy   <= w_busy_next;
      r_rddata <= w_rddata_next;
      r_valid  <= w_valid_next;
    end
  end

  assign miim_rddata       = r_rddata;
  assign miim_rddata_valid = r_valid;
  assign miim_busy         = r_busy;
  assign phy_mdc           = r_mdc;
  assign mdio_o            = r_o;
  assign mdio_oe           = r_oe;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: instance A (CLK_DIV=2, PRE_LEN=32) with a PHY read model, instance B (CLK_DIV=5, PRE_LEN=0).
module tb_mdio_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  a_phy, a_reg, b_phy, b_reg;
  logic [15:0] a_wd, b_wd;
  logic        a_wren, a_rden, b_wren, b_rden;
  logic        a_mdio_i, b_mdio_i;
  logic [15:0] a_rddata, b_rddata;
  logic        a_valid, a_busy, a_mdc, a_o, a_oe;
  logic        b_valid, b_busy, b_mdc, b_o, b_oe;
`ifdef MDIO_CL45_EN
  logic        a_cl45, b_cl45;
  logic [1:0]  a_op45, b_op45;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int n_valid_a = 0;
  int n_valid_b = 0;
  int n_frames_a = 0;
  int nf = 0;
  logic [15:0] phy_data = 16'h0000;
  logic [15:0] exp_q[$];
  logic [1:0]  cap_a[$];
  logic [1:0]  cap_b[$];

  mdio_master #(.CLK_DIV(2), .PRE_LEN(32), .IDLE_BITS(1)) u_a (
    .clk(clk), .rst(rst),
    .miim_phyad(a_phy), .miim_regad(a_reg), .miim_wrdata(a_wd),
    .miim_wren(a_wren), .miim_rden(a_rden),
`ifdef MDIO_CL45_EN
    .miim_cl45(a_cl45), .miim_op45(a_op45),
`endif
    .miim_rddata(a_rddata), .miim_rddata_valid(a_valid), .miim_busy(a_busy),
    .phy_mdc(a_mdc), .mdio_o(a_o), .mdio_oe(a_oe), .mdio_i(a_mdio_i)
  );

  mdio_master #(.CLK_DIV(5), .PRE_LEN(0), .IDLE_BITS(1)) u_b (
    .clk(clk), .rst(rst),
    .miim_phyad(b_phy), .miim_regad(b_reg), .miim_wrdata(b_wd),
    .miim_wren(b_wren), .miim_rden(b_rden),
`ifdef MDIO_CL45_EN
    .miim_cl45(b_cl45), .miim_op45(b_op45),
`endif
    .miim_rddata(b_rddata), .miim_rddata_valid(b_valid), .miim_busy(b_busy),
    .phy_mdc(b_mdc), .mdio_o(b_o), .mdio_oe(b_oe), .mdio_i(b_mdio_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected Clause 22/45 frame with a 32-bit preamble and a driven TA of 1,0.
  function automatic logic [63:0] frame64(input logic [1:0] st, input logic [1:0] op,
                                          input logic [4:0] ph, input logic [4:0] rg,
                                          input logic [15:0] d);
    return {32'hFFFF_FFFF, st, op, ph, rg, 2'b10, d};
  endfunction

  // Packs the first n captured entries (fld 0 = mdio_o, 1 = mdio_oe), first bit in the MSB.
  function automatic logic [63:0] pack(input bit sel_b, input bit fld, input int n);
    logic [63:0] v;
    logic [1:0]  e;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (sel_b) e = (i < cap_b.size()) ? cap_b[i] : 2'bxx;
      else       e = (i < cap_a.size()) ? cap_a[i] : 2'bxx;
      v = {v[62:0], e[fld]};
    end
    return v;
  endfunction

  // Line samples at each MDC rising edge.
  always @(posedge a_mdc) begin #1; cap_a.push_back({a_oe, a_o}); end
  always @(posedge b_mdc) begin #1; cap_b.push_back({b_oe, b_o}); end
  always @(posedge a_busy) begin nf = 0; n_frames_a++; end

  // PHY model for A: after MDC fall n the wire carries frame bit n; TA bit 2 is 0, then 16 data bits.
  always @(negedge a_mdc) begin
    if (a_busy) begin
      nf = nf + 1;
      #1;
      if (nf == 47) a_mdio_i = 1'b0;
      else if (nf >= 48 && nf <= 63) a_mdio_i = phy_data[63 - nf];
      else a_mdio_i = 1'b1;
    end
  end

  // Scoreboard: each valid pulse pops the expected read word.
  always @(posedge clk) begin
    #1;
    if (a_valid) begin
      n_valid_a++;
      if (exp_q.size() == 0) chk("a_valid_unexpected", a_valid, 1'b0);
      else chk("a_rddata_on_valid", a_rddata, exp_q.pop_front());
    end
    if (b_valid) n_valid_b++;
  end

  task automatic req_a(input logic wr, input logic rd, input logic [4:0] ph,
                       input logic [4:0] rg, input logic [15:0] d);
    @(negedge clk);
    a_phy = ph; a_reg = rg; a_wd = d; a_wren = wr; a_rden = rd;
    @(negedge clk);
    a_wren = 1'b0; a_rden = 1'b0;
    a_phy = ~ph; a_reg = ~rg; a_wd = ~d;
  endtask

  task automatic wait_done(input bit sel_b, output int cyc);
    int guard;
    cyc = 0;
    guard = 0;
    while ((sel_b ? b_busy : a_busy) && guard < 5000) begin
      @(posedge clk); #1;
      cyc++;
      guard++;
    end
    chk(sel_b ? "b_frame_end" : "a_frame_end", sel_b ? b_busy : a_busy, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, v0, f0, guard;
    a_phy = '0; a_reg = '0; a_wd = '0; a_wren = 1'b0; a_rden = 1'b0; a_mdio_i = 1'b1;
    b_phy = '0; b_reg = '0; b_wd = '0; b_wren = 1'b0; b_rden = 1'b0; b_mdio_i = 1'b1;
`ifdef MDIO_CL45_EN
    a_cl45 = 1'b0; a_op45 = 2'b00; b_cl45 = 1'b0; b_op45 = 2'b00;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mdc", a_mdc, 1'b0);
    chk("rst_mdio_o", a_o, 1'b1);
    chk("rst_mdio_oe", a_oe, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_rddata", a_rddata, 16'h0000);
    chk("rst_valid", a_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_mdc_held", a_mdc, 1'b0);

    // Clause 22 write, PHY 1 reg 0 data 0x3100
    cap_a.delete(); v0 = n_valid_a;
    req_a(1'b1, 1'b0, 5'd1, 5'd0, 16'h3100);
    chk("wr_busy_next_cycle", a_busy, 1'b1);
    wait_done(1'b0, cyc);
    $display("write phy=1 reg=0 data=3100 busy_cycles=%0d bits=%0d", cyc, cap_a.size());
    chk("wr_busy_cycles", cyc, 260);
    chk("wr_cap_count", cap_a.size(), 65);
    chk("wr_frame_bits", pack(1'b0, 1'b0, 64), frame64(2'b01, 2'b01, 5'd1, 5'd0, 16'h3100));
    chk("wr_oe_bits", pack(1'b0, 1'b1, 64), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_gap_entry", (cap_a.size() > 64) ? cap_a[64] : 2'bxx, 2'b01);
    chk("wr_no_valid", n_valid_a - v0, 0);

    // Clause 22 read, PHY 1 reg 4, PHY returns 0x01E1
    phy_data = 16'h01E1;
    exp_q.push_back(16'h01E1);
    cap_a.delete(); v0 = n_valid_a;
    req_a(1'b0, 1'b1, 5'd1, 5'd4, 16'h0000);
    wait_done(1'b0, cyc);
    $display("read phy=1 reg=4 rddata=%h valid_pulses=%0d", a_rddata, n_valid_a - v0);
    chk("rd_header_bits", pack(1'b0, 1'b0, 46), {18'd0, 32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd4});
    chk("rd_oe_bits", pack(1'b0, 1'b1, 64), 64'hFFFF_FFFF_FFFC_0000);
    chk("rd_valid_cycles", n_valid_a - v0, 1);
    chk("rd_rddata_held", a_rddata, 16'h01E1);
    chk("rd_scoreboard_empty", exp_q.size(), 0);

    // Strobe while busy must be ignored
    cap_a.delete(); f0 = n_frames_a;
    req_a(1'b1, 1'b0, 5'd3, 5'd5, 16'hA5A5);
    repeat (100) @(negedge clk);
    a_phy = 5'd30; a_reg = 5'd29; a_wd = 16'h0F0F; a_wren = 1'b1; a_rden = 1'b1;
    @(negedge clk);
    a_wren = 1'b0; a_rden = 1'b0;
    wait_done(1'b0, cyc);
    repeat (60) @(negedge clk);
    $display("busy-strobe write phy=3 reg=5 data=a5a5 frames=%0d bits=%0d", n_frames_a - f0, cap_a.size());
    chk("busy_strobe_frames", n_frames_a - f0, 1);
    chk("busy_strobe_cap_count", cap_a.size(), 65);
    chk("busy_strobe_bits", pack(1'b0, 1'b0, 64), frame64(2'b01, 2'b01, 5'd3, 5'd5, 16'hA5A5));

    // wren and rden together: write wins
    cap_a.delete(); v0 = n_valid_a;
    req_a(1'b1, 1'b1, 5'd9, 5'd17, 16'hC3C3);
    wait_done(1'b0, cyc);
    $display("wren+rden phy=9 reg=17 data=c3c3 bits=%0d", cap_a.size());
    chk("wr_rd_both_bits", pack(1'b0, 1'b0, 64), frame64(2'b01, 2'b01, 5'd9, 5'd17, 16'hC3C3));
    chk("wr_rd_both_no_valid", n_valid_a - v0, 0);

    // Reset at bit 40 of a read
    phy_data = 16'hFFFF;
    cap_a.delete(); v0 = n_valid_a;
    req_a(1'b0, 1'b1, 5'd2, 5'd2, 16'h0000);
    guard = 0;
    while (cap_a.size() < 40 && guard < 1000) begin @(negedge clk); guard++; end
    chk("rst_mid_reached_bit40", cap_a.size(), 40);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", a_busy, 1'b0);
    chk("rst_mid_oe", a_oe, 1'b0);
    chk("rst_mid_mdc", a_mdc, 1'b0);
    chk("rst_mid_mdio_o", a_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    $display("reset-mid-read busy=%0b valid_pulses=%0d", a_busy, n_valid_a - v0);
    chk("rst_mid_no_valid", n_valid_a - v0, 0);
    chk("rst_mid_stays_idle", a_busy, 1'b0);
    cap_a.delete();
    req_a(1'b1, 1'b0, 5'd4, 5'd6, 16'h5A0F);
    wait_done(1'b0, cyc);
    $display("post-reset write phy=4 reg=6 data=5a0f busy_cycles=%0d", cyc);
    chk("post_rst_busy_cycles", cyc, 260);
    chk("post_rst_bits", pack(1'b0, 1'b0, 64), frame64(2'b01, 2'b01, 5'd4, 5'd6, 16'h5A0F));

    // PRE_LEN=0, CLK_DIV=5
    cap_b.delete();
    @(negedge clk);
    b_phy = 5'd2; b_reg = 5'd3; b_wd = 16'h1234; b_wren = 1'b1;
    @(negedge clk);
    b_wren = 1'b0; b_phy = '0; b_reg = '0; b_wd = '0;
    cyc = 0;
    while (!b_mdc && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b_first_rise_cycles", cyc, 5);
    chk("b_first_bit_st0", b_o, 1'b0);
    cyc = 0;
    while (b_mdc && cyc < 100) begin @(posedge clk); #1; cyc++; end
    while (!b_mdc && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b_mdc_period", cyc, 10);
    wait_done(1'b1, cyc);
    $display("b write phy=2 reg=3 data=1234 bits=%0d", cap_b.size());
    chk("b_cap_count", cap_b.size(), 33);
    chk("b_frame_bits", pack(1'b1, 1'b0, 32), {32'd0, 2'b01, 2'b01, 5'd2, 5'd3, 2'b10, 16'h1234});

`ifdef MDIO_CL45_EN
    // Clause 45 address frame then read
    a_cl45 = 1'b1; a_op45 = 2'b00;
    cap_a.delete(); v0 = n_valid_a;
    req_a(1'b1, 1'b0, 5'd2, 5'd1, 16'h0007);
    wait_done(1'b0, cyc);
    $display("cl45 address prtad=2 devad=1 data=0007 bits=%0d", cap_a.size());
    chk("cl45_addr_bits", pack(1'b0, 1'b0, 64), frame64(2'b00, 2'b00, 5'd2, 5'd1, 16'h0007));
    chk("cl45_addr_no_valid", n_valid_a - v0, 0);
    a_op45 = 2'b11;
    phy_data = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    cap_a.delete(); v0 = n_valid_a;
    req_a(1'b0, 1'b1, 5'd2, 5'd1, 16'h0000);
    wait_done(1'b0, cyc);
    $display("cl45 read prtad=2 devad=1 rddata=%h", a_rddata);
    chk("cl45_rd_header", pack(1'b0, 1'b0, 46), {18'd0, 32'hFFFF_FFFF, 2'b00, 2'b11, 5'd2, 5'd1});
    chk("cl45_rd_oe_bits", pack(1'b0, 1'b1, 64), 64'hFFFF_FFFF_FFFC_0000);
    chk("cl45_rd_valid_cycles", n_valid_a - v0, 1);
    chk("cl45_rd_rddata", a_rddata, 16'hBEEF);
    a_cl45 = 1'b0; a_op45 = 2'b00;
`endif

    repeat (5) @(negedge clk);
    chk("a_scoreboard_drained", exp_q.size(), 0);
    chk("b_never_valid", n_valid_b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
Parametrised MIIM/MDIO management master, successor to the fixed-rate controller in the MAC.
- Takes single-cycle write/read requests from a PHY configurator and serialises IEEE 802.3 Clause 22 frames.
- Adds a programmable MDC divider, a configurable preamble length and a split tri-state pad interface.
- Returns read data with a valid pulse.
- Sits between the configurator logic and the top-level MDIO pad.

Parameters:
CLK_DIV, 10, clk cycles per MDC half-period; legal range >= 2; MDC = clk / (2*CLK_DIV)
PRE_LEN, 32, preamble bits of '1' sent before ST; legal range 0..32
IDLE_BITS, 1, MDC periods with mdio_oe=0 after every frame before busy drops

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
miim_phyad  input  5  PHY address, sampled at request accept
miim_regad  input  5  register address (Clause 45: DEVAD), sampled at accept
miim_wrdata  input  16  write data (Clause 45 address frame: register address), sampled at accept
miim_wren  input  1  write request strobe
miim_rden  input  1  read request strobe
miim_rddata  output  16  last read data
miim_rddata_valid  output  1  one-cycle pulse when miim_rddata is updated
miim_busy  output  1  frame in progress
phy_mdc  output  1  management clock
mdio_o  output  1  serial data out
mdio_oe  output  1  pad output enable
mdio_i  input  1  serial data in from pad

Behaviour:
- Reset values: phy_mdc=0, mdio_o=1, mdio_oe=0, miim_busy=0, miim_rddata=0, miim_rddata_valid=0; state=IDLE; divider=0.
- Divider: counts 0..CLK_DIV-1 and toggles phy_mdc on wrap, only while busy. In IDLE, phy_mdc is held 0 and the divider is held at 0.
- Edges: the master updates mdio_o/mdio_oe on the clk cycle of each MDC falling edge and samples mdio_i on the clk cycle of each MDC rising edge.
- Accept: in IDLE, (miim_wren|miim_rden)=1 latches phyad/regad/wrdata and the operation. miim_busy=1 from the next cycle.
  - wren and rden high together -> write wins.
  - Strobes while busy are ignored, not queued.
- States:
  - IDLE -> PRE (PRE_LEN bits of 1; skipped if PRE_LEN=0).
  - PRE -> HDR: 14 bits, MSB first: ST=01, OP (write=01, read=10), PHYAD[4:0], REGAD[4:0].
  - HDR -> TA: write drives 1,0. Read sets mdio_oe=0 for both TA bits; TA bit 2 is sampled but does not gate the transfer.
  - TA -> DATA: 16 bits, MSB first. Write drives wrdata. Read keeps mdio_oe=0 and shifts in mdio_i on each rising edge.
  - DATA -> GAP (IDLE_BITS MDC periods, mdio_oe=0, mdio_o=1) -> IDLE.
- Frame length with PRE_LEN=32: 64 MDC periods + gap.
- Read completion: miim_rddata updated and miim_rddata_valid pulsed for exactly 1 clk on the cycle the 16th data bit is sampled. No pulse for writes.
- miim_busy deasserts on the cycle GAP ends. A new request is acceptable in that same cycle's successor.
- mdio_oe=1 from the first preamble bit through the last driven bit of write data, or through the end of HDR for reads.
- Reset mid-frame: all outputs return to reset values the next cycle, no rddata_valid, frame abandoned. Partial MDC high time is permitted.

Optional Feature:
MDIO_CL45_EN
- Defined: adds input miim_cl45 (1 bit) and input miim_op45 (2 bits), sampled at accept.
  - When miim_cl45=1: ST=00 and OP=miim_op45 (00 address, 01 write, 11 read, 10 read-inc).
  - PHYAD field = PRTAD, REGAD field = DEVAD.
  - Address and write ops transmit miim_wrdata. Read ops behave as a Clause 22 read for TA/DATA.
  - miim_wren/miim_rden only initiate; miim_op45 selects the frame.
- Undefined: ports absent; Clause 22 only.

Test Plan:
- Write: CLK_DIV=2, PRE_LEN=32, phyad=1, regad=0, wrdata=0x3100 -> mdio_o captured at MDC rising edges = 32x'1',01,01,00001,00000,10,0011000100000000; busy high for 65 MDC periods; no valid pulse.
- Read: phyad=1, regad=4, model drives 0x01E1 after TA -> mdio_oe=0 from TA onward; miim_rddata=0x01E1 with 1-cycle valid pulse.
- PRE_LEN=0, CLK_DIV=5: write -> first MDC rising edge sees ST bit 0; MDC period = 10 clk.
- Request during busy: wren pulsed mid-frame -> ignored, exactly one frame emitted. wren+rden together -> write frame (OP=01).
- rst asserted at bit 40 of a read -> next cycle busy=0, mdio_oe=0, phy_mdc=0; no valid pulse; a following write completes normally.
- MDIO_CL45_EN: cl45=1, op45=00, phyad=2, regad=1, wrdata=0x0007 -> ST=00, OP=00, data 0x0007; a following op45=11 read returns model value 0xBEEF.
